pc_fetch_ctrl: RTL and testbench

- Fetch sequencer for the CPU core. Owns the program counter register and the next-PC selection (sequential, beq, j/jal, jr).
- Issues word fetches to instruction memory through a req/ack handshake and hands each instruction to decode through a valid/ready handshake.
- Sits between instruction memory and the decode/control unit. Decode/execute return branch and jump redirects in the cycle that decode accepts the instruction.

---
 rtl/pc_fetch_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Fetch sequencer for the CPU core. Owns the program counter and the next-PC
// selection (sequential, beq, j/jal, jr). It fetches one word at a time from
// instruction memory over a req/ack handshake, then holds the instruction for
// decode over a valid/ready handshake. Redirect information from
// decode/execute is only consumed in the cycle decode accepts the instruction.
//
// Parameters:
//   RESET_PC      PC loaded on reset (must be word aligned).
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   reset         synchronous, active-high reset
//   imem_req      fetch request to instruction memory (high in FETCH)
//   imem_addr     fetch address, always equal to pc
//   imem_ack      memory response strobe, qualifies imem_rdata
//   imem_rdata    fetched instruction word
//   instr         instruction presented to decode
//   instr_valid   instr and pc are valid for decode (high in HOLD)
//   decode_ready  decode accepts instr this cycle
//   beq_zero      branch condition true
//   is_branch     accepted instruction is beq
//   beq_imm       branch offset in words
//   is_jump       accepted instruction is j/jal
//   jump_index    j/jal target index
//   is_jr         accepted instruction is jr
//   jr_addr       jr target
//   pc            PC of the current fetch / instruction
//   pc_plus4      pc + 4 (jal link value)
//
// Optional feature, macro PC_FETCH_PERF_EN:
//   fetch_count   number of accepted instructions (wraps)
//   stall_count   cycles spent waiting on memory or decode (wraps)
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        decode_ready,
  input  logic        beq_zero,
  input  logic        is_branch,
  input  logic [15:0] beq_imm,
  input  logic        is_jump,
  input  logic [25:0] jump_index,
  input  logic        is_jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;

  logic        fetch_done;
  logic        accept;
  logic [31:0] seq_pc;
  logic [31:0] branch_offset;
  logic [31:0] redirect_pc;

  // ---------------------------------------------------------------------------
  // Handshake qualifiers. An ack outside FETCH and a ready outside HOLD are
  // simply not looked at.
  // ---------------------------------------------------------------------------
  assign fetch_done = (state_reg == FETCH) && imem_ack;
  assign accept     = (state_reg == HOLD) && decode_ready;

  // ---------------------------------------------------------------------------
  // Next-PC selection. Only used on accept; priority jr > jump > branch.
  // All adds are plain 32-bit so wrap past 32'hFFFF_FFFC is silent.
  // ---------------------------------------------------------------------------
  assign seq_pc        = pc_reg + 32'd4;
  assign branch_offset = {{14{beq_imm[15]}}, beq_imm, 2'b00};

  always_comb begin
    redirect_pc = seq_pc;
    if (is_jr) begin
      redirect_pc = {jr_addr[31:2], 2'b00};
    end else if (is_jump) begin
      redirect_pc = {seq_pc[31:28], jump_index, 2'b00};
    end else if (is_branch && beq_zero) begin
      redirect_pc = seq_pc + branch_offset;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and datapath next values.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    case (state_reg)
      IDLE: begin
        // One dead cycle after reset, then start fetching.
        state_next = FETCH;
      end
      FETCH: begin
        if (fetch_done) begin
          instr_next = imem_rdata;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          pc_next    = redirect_pc;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are pure decodes of the registered state, so imem_addr/pc/instr
  // are stable for as long as the FSM sits in a state.
  // ---------------------------------------------------------------------------
  assign imem_req    = (state_reg == FETCH);
  assign instr_valid = (state_reg == HOLD);
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign pc_plus4    = seq_pc;
  assign instr       = instr_reg;

`ifdef PC_FETCH_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters. Both wrap silently.
  // ---------------------------------------------------------------------------
  logic [31:0] fetch_count_reg;
  logic [31:0] stall_count_reg;
  logic        stall_cycle;

  assign stall_cycle = ((state_reg == FETCH) && !imem_ack) ||
                       ((state_reg == HOLD) && !decode_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_reg <= 32'd0;
      stall_count_reg <= 32'd0;
    end else begin
      if (accept) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
      if (stall_cycle) begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_reg;
  assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Scoreboard bench for pc_fetch_ctrl. The bench plays instruction memory and
// decode. Expected fetch addresses are pushed when an accept (with its
// redirect) is driven and popped when the DUT raises the next imem_req;
// expected instruction words are pushed when memory data is driven and popped
// when instr_valid appears. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        decode_ready;
  logic        beq_zero;
  logic        is_branch;
  logic [15:0] beq_imm;
  logic        is_jump;
  logic [25:0] jump_index;
  logic        is_jr;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int n_vectors     = 0;
  int n_miscompares = 0;

  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .decode_ready (decode_ready),
    .beq_zero     (beq_zero),
    .is_branch    (is_branch),
    .beq_imm      (beq_imm),
    .is_jump      (is_jump),
    .jump_index   (jump_index),
    .is_jr        (is_jr),
    .jr_addr      (jr_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4)
`ifdef PC_FETCH_PERF_EN
    ,
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_redirects();
    beq_zero   = 1'b0;
    is_branch  = 1'b0;
    beq_imm    = 16'h0;
    is_jump    = 1'b0;
    jump_index = 26'h0;
    is_jr      = 1'b0;
    jr_addr    = 32'h0;
  endtask

  // Wait (bounded) for imem_req, then pop and check the expected address.
  task automatic take_fetch(output logic [31:0] cur_pc);
    int waited = 0;
    while (!imem_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!imem_req) check_val("req_timeout", {31'd0, imem_req}, 32'd1);
    if (addr_q.size() == 0) begin
      check_val("addr_q_empty", 32'd0, 32'd1);
      cur_pc = 32'hxxxx_xxxx;
    end else begin
      cur_pc = addr_q.pop_front();
    end
    check_val("imem_addr", imem_addr, cur_pc);
    check_val("pc", pc, cur_pc);
    check_val("pc_plus4", pc_plus4, cur_pc + 32'd4);
    check_val("valid_in_fetch", {31'd0, instr_valid}, 32'd0);
  endtask

  // Memory responds after ack_dly wait cycles; redirect noise is driven
  // during the wait to show it has no effect outside accept.
  task automatic serve_fetch(input logic [31:0] cur_pc, input int ack_dly, input logic [31:0] data);
    logic [31:0] exp_instr;
    for (int i = 0; i < ack_dly; i++) begin
      is_jr   = 1'b1;
      jr_addr = 32'hDEAD_BEE0;
      is_jump = 1'b1;
      @(negedge clk);
      check_val("req_wait", {31'd0, imem_req}, 32'd1);
      check_val("addr_wait", imem_addr, cur_pc);
      check_val("valid_wait", {31'd0, instr_valid}, 32'd0);
    end
    clear_redirects();
    imem_ack   = 1'b1;
    imem_rdata = data;
    instr_q.push_back(data);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    exp_instr  = instr_q.pop_front();
    check_val("valid_after_ack", {31'd0, instr_valid}, 32'd1);
    check_val("instr", instr, exp_instr);
    check_val("req_in_hold", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic fetch_one(
    input int          ack_dly,
    input logic [31:0] data,
    input int          stall,
    input logic        br,
    input logic        bz,
    input logic [15:0] imm,
    input logic        jmp,
    input logic [25:0] idx,
    input logic        jr,
    input logic [31:0] jra,
    input logic [31:0] exp_next
  );
    logic [31:0] cur_pc;
    take_fetch(cur_pc);
    serve_fetch(cur_pc, ack_dly, data);
    // Decode stall; a stray ack with other data must not disturb instr.
    for (int i = 0; i < stall; i++) begin
      decode_ready = 1'b0;
      imem_ack     = 1'b1;
      imem_rdata   = ~data;
      @(negedge clk);
      check_val("stall_instr", instr, data);
      check_val("stall_pc", pc, cur_pc);
      check_val("stall_req", {31'd0, imem_req}, 32'd0);
      check_val("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    imem_ack     = 1'b0;
    decode_ready = 1'b1;
    is_branch    = br;
    beq_zero     = bz;
    beq_imm      = imm;
    is_jump      = jmp;
    jump_index   = idx;
    is_jr        = jr;
    jr_addr      = jra;
    addr_q.push_back(exp_next);
    @(negedge clk);
    decode_ready = 1'b0;
    clear_redirects();
    check_val("req_after_accept", {31'd0, imem_req}, 32'd1);
    $display("txn pc=%h instr=%h ack_dly=%0d stall=%0d next_pc=%h", cur_pc, data, ack_dly, stall, pc);
  endtask

  initial begin
    logic [31:0] cur_pc;
    reset        = 1'b1;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    decode_ready = 1'b0;
    clear_redirects();
    repeat (3) @(negedge clk);
    check_val("rst_req", {31'd0, imem_req}, 32'd0);
    check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("rst_pc", pc, RESET_PC);
    check_val("rst_instr", instr, 32'd0);
`ifdef PC_FETCH_PERF_EN
    check_val("rst_fetch_cnt", fetch_count, 32'd0);
    check_val("rst_stall_cnt", stall_count, 32'd0);
`endif
    // Release; an ack during the dead IDLE cycle must be ignored.
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0001;
    @(negedge clk);
    imem_ack = 1'b0;
    check_val("req_rise", {31'd0, imem_req}, 32'd1);
    check_val("idle_ack_ignored", {31'd0, instr_valid}, 32'd0);
    addr_q.push_back(RESET_PC);

    //         dly data          stl br   bz   imm       jmp  idx         jr   jra            next
    fetch_one(0, 32'h1000_0000, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_3004);
    fetch_one(3, 32'h1000_0004, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_3008);
    fetch_one(0, 32'h1000_0008, 4, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_300C);
    fetch_one(1, 32'h1000_000C, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_3010);
    // Taken beq at 3010, offset -4 words.
    fetch_one(0, 32'h1000_0010, 0, 1'b1, 1'b1, 16'hFFFC, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_3004);
    fetch_one(0, 32'h1000_0014, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_3008);
    fetch_one(2, 32'h1000_0018, 1, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_300C);
    fetch_one(0, 32'h1000_001C, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_3010);
    // Not-taken beq at 3010.
    fetch_one(0, 32'h1000_0020, 0, 1'b1, 1'b0, 16'hFFFC, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_3014);
    fetch_one(0, 32'h1000_0024, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_3018);
    fetch_one(0, 32'h1000_0028, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_301C);
    fetch_one(0, 32'h1000_002C, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_3020);
    // j at 3020 with index 0xC10; branch also set but loses priority.
    fetch_one(0, 32'h1000_0030, 0, 1'b1, 1'b1, 16'h0010, 1'b1, 26'h0000C10, 1'b0, 32'h0,    32'h0000_3040);
    // jr and j together: jr wins, low bits cleared.
    fetch_one(1, 32'h1000_0034, 2, 1'b0, 1'b0, 16'h0000, 1'b1, 26'h0000123, 1'b1, 32'h0040_0007, 32'h0040_0004);
    // jr to top of memory, then sequential wrap to 0.
    fetch_one(0, 32'h1000_0038, 0, 1'b1, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
    fetch_one(0, 32'h1000_003C, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_0000);
    // Forward taken branch from 0: 4 + 3*4 = 0x10.
    fetch_one(0, 32'h1000_0040, 0, 1'b1, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_0010);

    // Reset while holding a valid instruction.
    take_fetch(cur_pc);
    serve_fetch(cur_pc, 0, 32'h1000_0044);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("hold_rst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("hold_rst_pc", pc, RESET_PC);
    check_val("hold_rst_req", {31'd0, imem_req}, 32'd0);
    check_val("hold_rst_instr", instr, 32'd0);
`ifdef PC_FETCH_PERF_EN
    check_val("hold_rst_fetch_cnt", fetch_count, 32'd0);
    check_val("hold_rst_stall_cnt", stall_count, 32'd0);
`endif
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0002;
    @(negedge clk);
    imem_ack = 1'b0;
    check_val("stray_ack_valid", {31'd0, instr_valid}, 32'd0);
    check_val("stray_ack_req", {31'd0, imem_req}, 32'd1);
    addr_q.delete();
    addr_q.push_back(RESET_PC);
    fetch_one(1, 32'h2000_0000, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 1'b0, 32'h0,          32'h0000_3004);
    take_fetch(cur_pc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
